tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 159 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word-aligns the deserialized 10-bit stream by hunting for
// control tokens, then decodes each aligned symbol into a video byte or control value.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset
);

    localparam int TOK_W  = (LOCK_TOKENS    > 1) ? $clog2(LOCK_TOKENS)    : 1;
    localparam int TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int LOSS_W = (LOSS_TIMEOUT   > 1) ? $clog2(LOSS_TIMEOUT)   : 1;

    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         prev_raw_q, prev_raw_d;
    logic [9:0]         aligned_q, aligned_d;
    logic [7:0]         data_q, data_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic               de_q, de_d;
    logic [3:0]         bit_offset_q, bit_offset_d;
    logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [LOSS_W-1:0]  loss_cnt_q, loss_cnt_d;

    logic [19:0] window;
    logic [19:0] window_shifted;
    logic        is_token;
    logic [1:0]  token_val;
    logic [7:0]  q_bits;
    logic [7:0]  video_byte;

    // Two consecutive words cover every possible symbol boundary at offsets 0..9.
    always_comb begin
        window         = {raw_in, prev_raw_q};
        window_shifted = window >> bit_offset_q;
        aligned_d      = window_shifted[9:0];
        prev_raw_d     = raw_in;
    end

    always_comb begin
        is_token  = 1'b0;
        token_val = 2'b00;
        case (aligned_q)
            10'h354: begin is_token = 1'b1; token_val = 2'b00; end
            10'h0AB: begin is_token = 1'b1; token_val = 2'b01; end
            10'h154: begin is_token = 1'b1; token_val = 2'b10; end
            10'h2AB: begin is_token = 1'b1; token_val = 2'b11; end
            default: begin is_token = 1'b0; token_val = 2'b00; end
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects).
    always_comb begin
        q_bits        = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        video_byte    = '0;
        video_byte[0] = q_bits[0];
        for (int i = 1; i < 8; i++) begin
            video_byte[i] = aligned_q[8] ? (q_bits[i] ^ q_bits[i-1])
                                         : ~(q_bits[i] ^ q_bits[i-1]);
        end
    end

    always_comb begin
        if (is_token) begin
            de_d   = 1'b0;
            data_d = 8'h00;
            ctrl_d = token_val;
        end else begin
            de_d   = 1'b1;
            data_d = video_byte;
            ctrl_d = ctrl_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_offset_d = bit_offset_q;
        tok_cnt_d    = tok_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        case (state_q)
            SEARCH: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                tok_cnt_d = is_token ? tok_cnt_q + 1'b1 : '0;
                // Lock takes priority over a timeout landing on the same cycle.
                if (is_token && (tok_cnt_q == TOK_LAST)) begin
                    state_d    = LOCKED;
                    loss_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    bit_offset_d = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
                    tok_cnt_d    = '0;
                    tmo_cnt_d    = '0;
                end
            end
            LOCKED: begin
                if (is_token) begin
                    loss_cnt_d = '0;
                end else if (loss_cnt_q == LOSS_LAST) begin
                    state_d   = SEARCH;
                    tok_cnt_d = '0;
                    tmo_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q      <= SEARCH;
            prev_raw_q   <= '0;
            aligned_q    <= '0;
            data_q       <= '0;
            ctrl_q       <= '0;
            de_q         <= 1'b0;
            bit_offset_q <= '0;
            tok_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_raw_q   <= prev_raw_d;
            aligned_q    <= aligned_d;
            data_q       <= data_d;
            ctrl_q       <= ctrl_d;
            de_q         <= de_d;
            bit_offset_q <= bit_offset_d;
            tok_cnt_q    <= tok_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign data       = data_q;
    assign ctrl       = ctrl_q;
    assign de         = de_q;
    assign locked     = (state_q == LOCKED);
    assign bit_offset = bit_offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed alignment/lock/loss scenarios plus random
// traffic, all compared against a bit-window reference model kept in this file.
module tb_tmds_channel_decoder;
    localparam int LOCK_TOKENS    = 8;
    localparam int SEARCH_TIMEOUT = 64;
    localparam int LOSS_TIMEOUT   = 256;

    logic       clk_pixel = 1'b0;
    logic       clk_run   = 1'b0;
    logic       reset     = 1'b0;
    logic [9:0] raw_in    = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] bit_offset;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_prev, m_aligned, m_data, m_ctrl, m_de, m_locked, m_off;
    int m_run, m_dwell, m_quiet;

    tmds_channel_decoder #(
        .LOCK_TOKENS   (LOCK_TOKENS),
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .raw_in    (raw_in),
        .data      (data),
        .ctrl      (ctrl),
        .de        (de),
        .locked    (locked),
        .bit_offset(bit_offset)
    );

    // Clock / reset
    always #5 if (clk_run) clk_pixel = ~clk_pixel;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int token_value(input int w);
        case (w)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int decode_video(input int w);
        int q, d, b;
        q = w & 'hFF;
        if ((w & 'h200) != 0) q = (~q) & 'hFF;
        d = q & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((q >> i) ^ (q >> (i - 1))) & 1;
            if ((w & 'h100) == 0) b = b ^ 1;
            d = d | (b << i);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_aligned = 0; m_data = 0; m_ctrl = 0; m_de = 0;
        m_locked = 0; m_off = 0; m_run = 0; m_dwell = 0; m_quiet = 0;
    endtask

    // One clock edge of the reference: everything uses the values held before the edge.
    task automatic model_step(input int w);
        int tv, next_aligned;
        next_aligned = (((w << 10) | m_prev) >> m_off) & 'h3FF;
        tv = token_value(m_aligned);
        if (tv >= 0) begin
            m_de = 0; m_data = 0; m_ctrl = tv;
        end else begin
            m_de = 1; m_data = decode_video(m_aligned);
        end
        if (m_locked == 0) begin
            m_run = (tv >= 0) ? m_run + 1 : 0;
            if (m_run == LOCK_TOKENS) begin
                m_locked = 1; m_quiet = 0;
            end else if (m_dwell == SEARCH_TIMEOUT - 1) begin
                m_off = (m_off + 1) % 10; m_run = 0; m_dwell = 0;
            end else begin
                m_dwell++;
            end
        end else begin
            m_quiet = (tv >= 0) ? 0 : m_quiet + 1;
            if (m_quiet == LOSS_TIMEOUT) begin
                m_locked = 0; m_run = 0; m_dwell = 0;
            end
        end
        m_aligned = next_aligned;
        m_prev    = w;
    endtask

    task automatic compare_all();
        check("data", data, m_data);
        check("ctrl", ctrl, m_ctrl);
        check("de", de, m_de);
        check("locked", locked, m_locked);
        check("bit_offset", bit_offset, m_off);
    endtask

    // Driver tasks
    task automatic drive(input logic [9:0] w);
        raw_in = w;
        @(posedge clk_pixel);
        model_step(int'(w));
        #1;
        compare_all();
    endtask

    // Reset is asserted with the clock stopped so the clear must be asynchronous.
    task automatic do_reset();
        clk_run = 1'b0;
        raw_in  = 10'h3FF;
        #7;
        reset = 1'b1;
        #2;
        model_reset();
        check("rst_data", data, 0);
        check("rst_ctrl", ctrl, 0);
        check("rst_de", de, 0);
        check("rst_locked", locked, 0);
        check("rst_offset", bit_offset, 0);
        clk_run = 1'b1;
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    logic [9:0] tok_tbl [4];
    logic [9:0] t354;
    logic [9:0] rot354;
    int         lock_at;
    int         ever_locked;

    initial begin
        tok_tbl[0] = 10'h354; tok_tbl[1] = 10'h0AB;
        tok_tbl[2] = 10'h154; tok_tbl[3] = 10'h2AB;
        t354   = 10'h354;
        rot354 = {t354[6:0], t354[9:7]};   // token begins at raw bit 3
        model_reset();

        // Reset, then constant video: offset walks 0..9 and wraps, never locking.
        do_reset();
        for (int n = 1; n <= SEARCH_TIMEOUT * 11; n++) begin
            drive(10'h100);
            if (n % SEARCH_TIMEOUT == 0)
                check("offset_walk", bit_offset, (n / SEARCH_TIMEOUT) % 10);
        end
        check("walk_unlocked", locked, 0);

        // Aligned lock at offset 0 followed by video decode.
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            if (n <= 8) drive(10'h354);
            else if (n == 9) drive(10'h100);
            else if (n == 10) drive(10'h200);
            else drive(10'h354);
            if (n == 9) check("lock_early", locked, 0);
            if (n == 10) begin
                check("lock_rise", locked, 1);
                check("lock_ctrl", ctrl, 0);
                check("lock_de", de, 0);
            end
            if (n == 11) begin
                check("vid100_de", de, 1);
                check("vid100_data", data, 8'h00);
            end
            if (n == 12) begin
                check("vid200_de", de, 1);
                check("vid200_data", data, 8'hFF);
            end
        end

        // Control decode at two-cycle latency.
        for (int n = 1; n <= 5; n++) begin
            if (n <= 3) drive(tok_tbl[n]);
            else drive(10'h354);
            if (n >= 3) begin
                check("ctrl_dec", ctrl, n - 2);
                check("ctrl_de", de, 0);
                check("ctrl_data", data, 0);
            end
        end

        // Loss with a single restarting token at LOSS_TIMEOUT-2.
        for (int n = 1; n <= 2 * LOSS_TIMEOUT; n++) begin
            drive((n == LOSS_TIMEOUT - 2) ? 10'h354 : 10'h100);
            if (n == LOSS_TIMEOUT + 2) check("restart_hold", locked, 1);
            if (n == 2 * LOSS_TIMEOUT - 1) check("restart_prefall", locked, 1);
            if (n == 2 * LOSS_TIMEOUT) check("restart_fall", locked, 0);
        end

        // Near-miss: seven tokens then a video word never reaches lock.
        do_reset();
        ever_locked = 0;
        for (int n = 1; n <= SEARCH_TIMEOUT * 10 + 8; n++) begin
            drive((n % 8 == 0) ? 10'h100 : 10'h354);
            if (locked) ever_locked = 1;
            if (n % SEARCH_TIMEOUT == 0)
                check("nearmiss_offset", bit_offset, (n / SEARCH_TIMEOUT) % 10);
        end
        check("nearmiss_never", ever_locked, 0);

        // Misaligned stream: lock found at offset 3 after three timeouts.
        do_reset();
        lock_at = 0;
        for (int n = 1; n <= 1000; n++) begin
            drive(rot354);
            if (locked && lock_at == 0) lock_at = n;
            if (lock_at != 0 && n >= lock_at + 4) break;
        end
        check("mis_lock_cycle", lock_at, 3 * SEARCH_TIMEOUT + LOCK_TOKENS + 1);
        check("mis_offset", bit_offset, 3);

        // Video-only loss at offset 3: falls after LOSS_TIMEOUT, offset kept.
        for (int n = 1; n <= LOSS_TIMEOUT + 3; n++) begin
            drive(10'h100);
            if (n == LOSS_TIMEOUT) check("loss_prefall", locked, 1);
            if (n == LOSS_TIMEOUT + 1) begin
                check("loss_fall", locked, 0);
                check("loss_offset", bit_offset, 3);
            end
        end

        // Random traffic: token-rich, then token-starved.
        do_reset();
        for (int n = 0; n < 10; n++) drive(10'h354);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) drive(tok_tbl[$urandom_range(0, 3)]);
            else drive(10'($urandom_range(0, 1023)));
        end
        for (int n = 0; n < 400; n++) drive(10'($urandom_range(0, 1023)));

        // Mid-operation reset with no clock.
        do_reset();
        drive(10'h354);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
